// File: rtl/sdram_rd_arbiter_pkg.sv
// Shared types and constants for the video mixer SDRAM read path.
// Holds the SDRAM word-address type, the data width, the requester ID type
// with names for each requester index, the arbiter state encoding, and a
// round-robin wrap helper.

package sdram_rd_arbiter_pkg;

   // SDRAM word address used by every read master in the mixer
   localparam int cADDR_W = 24;
   typedef logic [cADDR_W-1:0] tADDR;

   // Width of one SDRAM data beat
   localparam int cDATA_W = 16;

   // Requesters sharing the read master: four BG renderers, then the sprite engine
   localparam int cRD_REQ_NUM = 5;
   typedef logic [2:0] tREQ_ID;

   localparam tREQ_ID cREQ_BG0 = 3'd0;
   localparam tREQ_ID cREQ_BG1 = 3'd1;
   localparam tREQ_ID cREQ_BG2 = 3'd2;
   localparam tREQ_ID cREQ_BG3 = 3'd3;
   localparam tREQ_ID cREQ_SPR = 3'd4;

   // Arbiter states: waiting for a request, or holding one read on the bus
   typedef enum logic {
      sIDLE  = 1'b0,
      sISSUE = 1'b1
   } tRD_STATE;

   // Next requester index after id, wrapping at num
   function automatic tREQ_ID nextReqId(input tREQ_ID id, input int num);
      return (int'(id) == (num - 1)) ? '0 : id + 1'b1;
   endfunction

endpackage

// File: rtl/sdram_rd_tag_fifo.sv
// In-order FIFO of requester IDs for reads accepted by SDRAM but not yet
// returned. The pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter. A push and a pop in the same
// cycle are both honoured, including when the FIFO is full.

module sdram_rd_tag_fifo
   import sdram_rd_arbiter_pkg::*;
#(
   parameter int pDEPTH = 4
)
(
   input  logic   iCLOCK,
   input  logic   iRESET_N,
   input  logic   iPUSH,
   input  tREQ_ID iPUSH_DATA,
   input  logic   iPOP,
   output tREQ_ID oHEAD,
   output logic   oFULL,
   output logic   oEMPTY
);

   localparam int cAW = $clog2(pDEPTH);

   logic [cAW:0] rWrPtr;
   logic [cAW:0] rRdPtr;
   tREQ_ID       rMem [pDEPTH];
   logic         doPush;
   logic         doPop;

   assign oEMPTY = (rWrPtr == rRdPtr);
   assign oFULL  = (rWrPtr[cAW] != rRdPtr[cAW]) &&
                   (rWrPtr[cAW-1:0] == rRdPtr[cAW-1:0]);
   assign oHEAD  = rMem[rRdPtr[cAW-1:0]];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is fine then
   assign doPop  = iPOP && !oEMPTY;
   assign doPush = iPUSH && (!oFULL || doPop);

   // Pointer update; reset discards every pending tag
   always_ff @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         rWrPtr <= '0;
         rRdPtr <= '0;
      end else begin
         if (doPush) begin
            rWrPtr <= rWrPtr + 1'b1;
         end
         if (doPop) begin
            rRdPtr <= rRdPtr + 1'b1;
         end
      end
   end

   // Tag storage; contents are only meaningful between the pointers
   always_ff @(posedge iCLOCK) begin
      if (doPush) begin
         rMem[rWrPtr[cAW-1:0]] <= iPUSH_DATA;
      end
   end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Shares the single Avalon-MM SDRAM read master between the BG renderers and
// the sprite engine. Requests are granted round-robin, one read at a time.
// Every accepted read leaves its requester ID in an in-order tag FIFO, and each
// readdatavalid beat is routed back to the requester at the head of that FIFO.
// A beat arriving with no pending tag is dropped and latches a sticky error.

module sdram_rd_arbiter
   import sdram_rd_arbiter_pkg::*;
#(
   parameter int pREQ_NUM     = 4,
   parameter int pMAX_PENDING = 4
)
(
   input  logic                iCLOCK,
   input  logic                iRESET_N,
   input  logic [pREQ_NUM-1:0] iREQ_READ,
   input  tADDR [pREQ_NUM-1:0] iREQ_ADDRESS,
   output logic [pREQ_NUM-1:0] oREQ_WAIT_REQUEST,
   output logic [cDATA_W-1:0]  oREQ_READ_DATA,
   output logic [pREQ_NUM-1:0] oREQ_READ_DATA_VALID,
   output logic                oERROR,
   output tADDR                oSDRAM_ADDRESS,
   output logic                oSDRAM_READ,
   input  logic                iSDRAM_WAIT_REQUEST,
   input  logic [cDATA_W-1:0]  iSDRAM_READ_DATA,
   input  logic                iSDRAM_READ_DATA_VALID
);

   tRD_STATE            rState;
   tREQ_ID              rGNT;
   tREQ_ID              rPTR;

   logic                anyReq;
   tREQ_ID              winnerId;
   tADDR                winnerAddr;
   logic                accept;

   logic                fifoFull;
   logic                fifoEmpty;
   tREQ_ID              fifoHead;
   logic                popTag;
   logic [pREQ_NUM-1:0] headOneHot;

   // The read is taken by SDRAM on any cycle it is on the bus without waitrequest
   assign accept = (rState == sISSUE) && oSDRAM_READ && !iSDRAM_WAIT_REQUEST;

   // Only a beat with a pending tag is routed; the rest count as errors
   assign popTag = iSDRAM_READ_DATA_VALID && !fifoEmpty;

   sdram_rd_tag_fifo #(
      .pDEPTH     (pMAX_PENDING)
   ) tagFifo (
      .iCLOCK     (iCLOCK),
      .iRESET_N   (iRESET_N),
      .iPUSH      (accept),
      .iPUSH_DATA (rGNT),
      .iPOP       (popTag),
      .oHEAD      (fifoHead),
      .oFULL      (fifoFull),
      .oEMPTY     (fifoEmpty)
   );

   // Round-robin pick: first requester at or after rPTR, then wrap to the low indices
   always_comb begin
      anyReq     = 1'b0;
      winnerId   = '0;
      winnerAddr = '0;
      for (int i = 0; i < pREQ_NUM; i++) begin
         if (!anyReq && iREQ_READ[i] && (tREQ_ID'(i) >= rPTR)) begin
            anyReq     = 1'b1;
            winnerId   = tREQ_ID'(i);
            winnerAddr = iREQ_ADDRESS[i];
         end
      end
      for (int i = 0; i < pREQ_NUM; i++) begin
         if (!anyReq && iREQ_READ[i]) begin
            anyReq     = 1'b1;
            winnerId   = tREQ_ID'(i);
            winnerAddr = iREQ_ADDRESS[i];
         end
      end
   end

   // Release only the granted requester, and only in the cycle SDRAM takes its read
   always_comb begin
      oREQ_WAIT_REQUEST = '1;
      for (int i = 0; i < pREQ_NUM; i++) begin
         if (accept && (rGNT == tREQ_ID'(i))) begin
            oREQ_WAIT_REQUEST[i] = 1'b0;
         end
      end
   end

   // Decode the FIFO head into the return strobe pattern
   always_comb begin
      headOneHot = '0;
      for (int i = 0; i < pREQ_NUM; i++) begin
         if (fifoHead == tREQ_ID'(i)) begin
            headOneHot[i] = 1'b1;
         end
      end
   end

   // Issue FSM: grant when a tag slot is free, hold the read until SDRAM accepts it
   always_ff @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         rState         <= sIDLE;
         rGNT           <= '0;
         rPTR           <= '0;
         oSDRAM_ADDRESS <= '0;
         oSDRAM_READ    <= 1'b0;
      end else begin
         case (rState)
            sIDLE: begin
               if (anyReq && !fifoFull) begin
                  rGNT           <= winnerId;
                  oSDRAM_ADDRESS <= winnerAddr;
                  oSDRAM_READ    <= 1'b1;
                  rState         <= sISSUE;
               end
            end
            sISSUE: begin
               if (accept) begin
                  rPTR        <= nextReqId(rGNT, pREQ_NUM);
                  oSDRAM_READ <= 1'b0;
                  rState      <= sIDLE;
               end
            end
            default: begin
               oSDRAM_READ <= 1'b0;
               rState      <= sIDLE;
            end
         endcase
      end
   end

   // Return path: route each beat to the oldest pending requester one cycle later
   always_ff @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         oREQ_READ_DATA_VALID <= '0;
         oREQ_READ_DATA       <= '0;
         oERROR               <= 1'b0;
      end else begin
         oREQ_READ_DATA_VALID <= popTag ? headOneHot : '0;
         if (popTag) begin
            oREQ_READ_DATA <= iSDRAM_READ_DATA;
         end
         if (iSDRAM_READ_DATA_VALID && fifoEmpty) begin
            oERROR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Testbench for sdram_rd_arbiter. Requesters and an SDRAM stub are driven
// from the initial block; a transaction-level model (pending-ID queue plus
// round-robin pointer) predicts every output and is compared each cycle on
// the falling clock edge. Directed sections pin the model with literal values.

module tb_sdram_rd_arbiter;
   import sdram_rd_arbiter_pkg::*;

   localparam int N     = 4;
   localparam int DEPTH = 4;

   logic          iCLOCK   = 1'b0;
   logic          iRESET_N = 1'b1;
   logic [N-1:0]  reqRead  = '0;
   tADDR [N-1:0]  reqAddr  = '0;
   logic [N-1:0]  waitReq;
   logic [15:0]   rdData;
   logic [N-1:0]  rdValid;
   logic          err;
   tADDR          sdAddr;
   logic          sdRead;
   logic          sdWait   = 1'b0;
   logic [15:0]   sdData   = '0;
   logic          sdValid  = 1'b0;

   int checks = 0;
   int errors = 0;

   sdram_rd_arbiter #(
      .pREQ_NUM               (N),
      .pMAX_PENDING           (DEPTH)
   ) dut (
      .iCLOCK                 (iCLOCK),
      .iRESET_N               (iRESET_N),
      .iREQ_READ              (reqRead),
      .iREQ_ADDRESS           (reqAddr),
      .oREQ_WAIT_REQUEST      (waitReq),
      .oREQ_READ_DATA         (rdData),
      .oREQ_READ_DATA_VALID   (rdValid),
      .oERROR                 (err),
      .oSDRAM_ADDRESS         (sdAddr),
      .oSDRAM_READ            (sdRead),
      .iSDRAM_WAIT_REQUEST    (sdWait),
      .iSDRAM_READ_DATA       (sdData),
      .iSDRAM_READ_DATA_VALID (sdValid)
   );

   // Clock generation
   always #5 iCLOCK = ~iCLOCK;

   // Stimulus knobs and stub state
   int          reqProb   = 0;
   int          waitProb  = 0;
   int          latency   = 1;
   bit          forceWait = 1'b0;
   logic [15:0] dataKey   = 16'h5A5A;
   int          cycleCount = 0;
   int          retDue[$];
   logic [15:0] retData[$];
   tADDR        issueLog[$];
   int          maxOut = 0;
   logic [N-1:0] waitSamp = '1;
   bit          acceptSamp = 1'b0;
   tADDR        addrSamp = '0;
   bit          checkEn = 1'b0;

   // Behavioural model state
   bit           mBusy = 1'b0;
   int           mGnt = 0;
   int           mPtr = 0;
   tADDR         mAddr = '0;
   int           tagQ[$];
   logic [N-1:0] expValid = '0;
   logic [15:0]  expData = '0;
   logic         mErr = 1'b0;
   int           fullBefore;
   int           cand;
   int           headId;
   bit           found;
   logic [N-1:0] expWait;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: reads are pending IDs in a queue; one read on the bus at a time
   always @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         mBusy = 1'b0;
         mGnt = 0;
         mPtr = 0;
         mAddr = '0;
         tagQ.delete();
         expValid = '0;
         mErr = 1'b0;
      end else begin
         fullBefore = tagQ.size();
         expValid = '0;
         if (sdValid) begin
            if (tagQ.size() > 0) begin
               headId = tagQ.pop_front();
               expValid[headId] = 1'b1;
               expData = sdData;
            end else begin
               mErr = 1'b1;
            end
         end
         if (mBusy && !sdWait) begin
            tagQ.push_back(mGnt);
            mPtr = (mGnt + 1) % N;
            mBusy = 1'b0;
         end else if (!mBusy && fullBefore < DEPTH) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               cand = (mPtr + k) % N;
               if (!found && reqRead[cand]) begin
                  found = 1'b1;
                  mGnt = cand;
                  mAddr = reqAddr[cand];
                  mBusy = 1'b1;
               end
            end
         end
      end
   end

   // Compare DUT against the model on the falling edge; also sample for the stubs
   always @(negedge iCLOCK) begin
      waitSamp = waitReq;
      acceptSamp = sdRead && !sdWait;
      addrSamp = sdAddr;
      if (checkEn && iRESET_N) begin
         expWait = '1;
         if (mBusy && !sdWait) expWait[mGnt] = 1'b0;
         checkOutput("sdramRead", 32'(sdRead), 32'(mBusy));
         if (mBusy) checkOutput("sdramAddr", 32'(sdAddr), 32'(mAddr));
         checkOutput("waitReq", 32'(waitReq), 32'(expWait));
         checkOutput("dataValid", 32'(rdValid), 32'(expValid));
         if (expValid != '0) checkOutput("readData", 32'(rdData), 32'(expData));
         checkOutput("error", 32'(err), 32'(mErr));
      end
   end

   // One clock of requester and SDRAM stub behaviour
   task automatic applyStimulus();
      @(posedge iCLOCK);
      #1;
      cycleCount++;
      for (int i = 0; i < N; i++) begin
         if (reqRead[i] && !waitSamp[i]) reqRead[i] = 1'b0;
         if (!reqRead[i] && ($urandom_range(99) < reqProb)) begin
            reqRead[i] = 1'b1;
            reqAddr[i] = {4'(i), 20'($urandom)};
         end
      end
      if (acceptSamp) begin
         issueLog.push_back(addrSamp);
         retDue.push_back(cycleCount + latency - 1);
         retData.push_back(addrSamp[15:0] ^ dataKey);
      end
      if (retDue.size() > maxOut) maxOut = retDue.size();
      sdValid = 1'b0;
      if (retDue.size() > 0 && retDue[0] <= cycleCount) begin
         void'(retDue.pop_front());
         sdData = retData.pop_front();
         sdValid = 1'b1;
      end
      sdWait = forceWait || ($urandom_range(99) < waitProb);
   endtask

   task automatic resetDut();
      #2 iRESET_N = 1'b0;
      reqRead = '0;
      sdValid = 1'b0;
      retDue.delete();
      retData.delete();
      repeat (2) @(posedge iCLOCK);
      #1 iRESET_N = 1'b1;
   endtask

   int phReq[6]  = '{30, 70, 100, 100, 50, 100};
   int phWait[6] = '{0, 30, 0, 0, 60, 20};
   int phLat[6]  = '{1, 3, 6, 10, 2, 10};
   int budget;

   initial begin
      // Reset values
      resetDut();
      checkOutput("rstRead", 32'(sdRead), 32'h0);
      checkOutput("rstAddr", 32'(sdAddr), 32'h0);
      checkOutput("rstValid", 32'(rdValid), 32'h0);
      checkOutput("rstError", 32'(err), 32'h0);
      checkOutput("rstWait", 32'(waitReq), 32'hF);
      checkEn = 1'b1;

      // All requesters busy from reset: grants go 0,1,2,3,0
      reqProb = 100; waitProb = 0; latency = 6;
      issueLog.delete();
      repeat (30) applyStimulus();
      checkOutput("t2IssueCount", 32'(issueLog.size() >= 5), 32'h1);
      if (issueLog.size() >= 5) begin
         for (int k = 0; k < 5; k++) checkOutput("t2GrantOrder", 32'(issueLog[k][23:20]), 32'(k % 4));
      end
      resetDut();

      // Single request from requester 1
      reqProb = 0; waitProb = 0; latency = 1; forceWait = 1'b0;
      dataKey = 16'h1234 ^ 16'hBEEF;
      applyStimulus();
      reqRead[1] = 1'b1;
      reqAddr[1] = 24'h001234;
      applyStimulus();
      #3;
      checkOutput("t1Read", 32'(sdRead), 32'h1);
      checkOutput("t1Addr", 32'(sdAddr), 32'h001234);
      checkOutput("t1Wait", 32'(waitReq), 32'hD);
      applyStimulus();
      #3;
      checkOutput("t1ReadDrop", 32'(sdRead), 32'h0);
      applyStimulus();
      #3;
      checkOutput("t1Valid", 32'(rdValid), 32'h2);
      checkOutput("t1Data", 32'(rdData), 32'hBEEF);
      applyStimulus();
      #3;
      checkOutput("t1ValidDrop", 32'(rdValid), 32'h0);
      dataKey = 16'h5A5A;

      // Waitrequest held on a requester 2 issue while requester 0 also asks
      forceWait = 1'b1;
      reqRead[2] = 1'b1; reqAddr[2] = 24'h2ABCDE;
      reqRead[0] = 1'b1; reqAddr[0] = 24'h0000AA;
      applyStimulus();
      repeat (5) begin
         applyStimulus();
         #3;
         checkOutput("t3Read", 32'(sdRead), 32'h1);
         checkOutput("t3Addr", 32'(sdAddr), 32'h2ABCDE);
         checkOutput("t3Wait", 32'(waitReq), 32'hF);
      end
      forceWait = 1'b0;
      applyStimulus();
      #3;
      checkOutput("t3Accept", 32'(waitReq), 32'hB);
      repeat (10) applyStimulus();

      // Randomised phases, including long latency with everyone requesting
      for (int p = 0; p < 6; p++) begin
         reqProb = phReq[p]; waitProb = phWait[p]; latency = phLat[p];
         maxOut = 0;
         repeat (250) applyStimulus();
         if (p == 3) checkOutput("t4MaxOutstanding", 32'(maxOut), 32'h4);
      end

      // Drain, then a spurious beat with nothing pending
      reqProb = 0; waitProb = 0;
      repeat (60) applyStimulus();
      sdValid = 1'b1; sdData = 16'h1111;
      applyStimulus();
      #3;
      checkOutput("t5Error", 32'(err), 32'h1);
      checkOutput("t5NoValid", 32'(rdValid), 32'h0);
      repeat (5) applyStimulus();
      #3;
      checkOutput("t5ErrorHeld", 32'(err), 32'h1);

      // Reset with several reads pending
      reqProb = 100; latency = 10;
      budget = 0;
      while (tagQ.size() < 3 && budget < 200) begin
         applyStimulus();
         budget++;
      end
      checkOutput("t6Pending", 32'(tagQ.size() >= 3), 32'h1);
      #2 iRESET_N = 1'b0;
      #1;
      checkOutput("t6RstRead", 32'(sdRead), 32'h0);
      checkOutput("t6RstValid", 32'(rdValid), 32'h0);
      checkOutput("t6RstError", 32'(err), 32'h0);
      checkOutput("t6RstWait", 32'(waitReq), 32'hF);
      reqProb = 0; reqRead = '0; sdValid = 1'b0;
      retDue.delete(); retData.delete();
      repeat (2) @(posedge iCLOCK);
      #1 iRESET_N = 1'b1;
      latency = 2;
      reqRead[0] = 1'b1; reqAddr[0] = 24'h000321;
      applyStimulus();
      #3;
      checkOutput("t6FreshAddr", 32'(sdAddr), 32'h000321);
      checkOutput("t6FreshWait", 32'(waitReq), 32'hE);
      repeat (10) applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
